// File: rtl/mult_pkg.sv
// Shared state encoding and sizing helper for the shift-add multiplier.
`default_nettype none

package mult_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } mult_state_t;

  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_addsub.sv
// WIDTH+1-bit adder/subtractor; sext selects sign- or zero-extension of both operands.
`default_nettype none

module mult_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  input  logic             sub,
  input  logic             sext,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] m_ext;

  assign a_ext = {sext & a[WIDTH-1], a};
  assign m_ext = {sext & m[WIDTH-1], m};
  // Carry out of WIDTH+1 bits is dropped by the result width
  assign sum   = sub ? (a_ext - m_ext) : (a_ext + m_ext);

endmodule

`default_nettype wire

// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier: product of latched S and register B ends up in {A,B}.
// Define MULT_SIGNED_EN for two's-complement operation; unsigned otherwise.
`default_nettype none

module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef MULT_SIGNED_EN
  localparam logic SIGNED_MODE = 1'b1;
`else
  localparam logic SIGNED_MODE = 1'b0;
`endif

  mult_state_t      state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] m;
  logic             x;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             done;

  logic             sub_last;
  logic [WIDTH:0]   sum;

  // The multiplier's sign bit carries negative weight, hence the final subtract
  assign sub_last = SIGNED_MODE && (cnt == CNT_LAST);

  mult_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (a),
    .m    (m),
    .sub  (sub_last),
    .sext (SIGNED_MODE),
    .sum  (sum)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      m     <= '0;
      x     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Run) begin
            state <= START;
            busy  <= 1'b1;
          end else if (ClearA_LoadB) begin
            a <= '0;
            x <= 1'b0;
            b <= S;
          end
        end
        START: begin
          a     <= '0;
          x     <= 1'b0;
          m     <= S;
          cnt   <= '0;
          state <= ADD;
        end
        ADD: begin
          if (b[0]) {x, a} <= sum;
          state <= SHIFT;
        end
        SHIFT: begin
          a <= {x, a[WIDTH-1:1]};
          b <= {a[0], b[WIDTH-1:1]};
          // Unsigned: X was a carry, consumed by this shift
          if (!SIGNED_MODE) x <= 1'b0;
          if (cnt == CNT_LAST) begin
            state <= HOLD;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= ADD;
          end
        end
        HOLD: begin
          if (!Run) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Aval = a;
  assign Bval = b;
  assign X    = x;
  assign Busy = busy;
  assign Done = done;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult: arithmetic/timing model plus directed literal vectors.
`default_nettype none

module tb_shift_add_mult;

  localparam int W = 8;

`ifdef MULT_SIGNED_EN
  localparam bit SG = 1'b1;
`else
  localparam bit SG = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Run = 1'b0;
  logic         ClearA_LoadB = 1'b0;
  logic [W-1:0] S = '0;
  logic [W-1:0] Aval;
  logic [W-1:0] Bval;
  logic         X;
  logic         Busy;
  logic         Done;

  int checks = 0;
  int errors = 0;

  shift_add_mult #(.WIDTH(W)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .S            (S),
    .Aval         (Aval),
    .Bval         (Bval),
    .X            (X),
    .Busy         (Busy),
    .Done         (Done)
  );

  always #5 Clk = ~Clk;

  // Model: X,A,B = full product of B and multiplicand after 2W+1 busy cycles.
  function automatic logic [2*W:0] model_result(input logic [W-1:0] bv, input logic [W-1:0] mv);
    logic signed [2*W-1:0] ps;
    logic [2*W-1:0]        pu;
    ps = $signed({{W{bv[W-1]}}, bv}) * $signed({{W{mv[W-1]}}, mv});
    pu = {{W{1'b0}}, bv} * {{W{1'b0}}, mv};
    if (SG) return {ps[2*W-1], ps};
    return {1'b0, pu};
  endfunction

  logic         m_busy, m_done;
  int           m_rem;
  logic [W-1:0] ea, eb, mm;
  logic         ex;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_rem <= 0;
      ea <= '0; eb <= '0; ex <= 1'b0; mm <= '0;
    end else if (m_busy) begin
      if (m_rem == 2*W+1) mm <= S;
      if (m_rem == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        {ex, ea, eb} <= model_result(eb, mm);
      end
      m_rem <= m_rem - 1;
    end else if (m_done) begin
      if (!Run) m_done <= 1'b0;
    end else if (Run) begin
      m_busy <= 1'b1;
      m_rem  <= 2*W+1;
    end else if (ClearA_LoadB) begin
      ea <= '0; ex <= 1'b0; eb <= S;
    end
  end

  // Status every cycle; register contents whenever not mid-operation
  always @(negedge Clk) begin
    if (!Reset) begin
      checks++;
      if ({Busy, Done} !== {m_busy, m_done}) begin
        errors++;
        $display("FAIL status: got busy/done %b%b expected %b%b at %0t", Busy, Done, m_busy, m_done, $time);
      end
      if (!m_busy) begin
        checks++;
        if ({X, Aval, Bval} !== {ex, ea, eb}) begin
          errors++;
          $display("FAIL regs: got X=%b A=%h B=%h expected X=%b A=%h B=%h at %0t", X, Aval, Bval, ex, ea, eb, $time);
        end
      end
    end
  end

  task automatic check(input string name, input logic [2*W+1:0] got, input logic [2*W+1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_mult(input string name, input logic [W-1:0] bv, input logic [W-1:0] sv,
                         input bit load, input bit pulse, input logic [2*W:0] exp_xab,
                         input int hold_extra);
    int n;
    n = 0;
    if (load) begin
      @(negedge Clk); ClearA_LoadB = 1'b1; S = bv;
      @(negedge Clk); ClearA_LoadB = 1'b0;
    end
    @(negedge Clk); S = sv; Run = 1'b1;
    for (int i = 1; i <= 4*W; i++) begin
      @(negedge Clk);
      if (pulse && i == 6) begin ClearA_LoadB = 1'b1; S = 8'h55; end
      if (pulse && i == 7) ClearA_LoadB = 1'b0;
      if (Done) begin n = i; break; end
    end
    check({name, " latency"}, (2*W+2)'(n), (2*W+2)'(2*W+2));
    check({name, " dut"},   {1'b0, X, Aval, Bval}, {1'b0, exp_xab});
    check({name, " model"}, {1'b0, ex, ea, eb},    {1'b0, exp_xab});
    repeat (hold_extra) @(negedge Clk);
    check({name, " hold"}, {Busy, Done, X, Aval, Bval}, {2'b01, exp_xab});
    Run = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    check("reset", {Busy, Done, X, Aval, Bval}, '0);
    Reset = 1'b0;

    do_mult("7x3b", 8'h07, 8'h3B, 1'b1, 1'b0, {1'b0, 16'h019D}, 0);
    do_mult("chain", 8'h00, 8'h02, 1'b0, 1'b0, SG ? {1'b1, 16'hFF3A} : {1'b0, 16'h013A}, 5);
    do_mult("3xfe", 8'h03, 8'hFE, 1'b1, 1'b0, SG ? {1'b1, 16'hFFFA} : {1'b0, 16'h02FA}, 0);
    do_mult("fex3", 8'hFE, 8'h03, 1'b1, 1'b0, SG ? {1'b1, 16'hFFFA} : {1'b0, 16'h02FA}, 0);
    do_mult("80x80", 8'h80, 8'h80, 1'b1, 1'b0, {1'b0, 16'h4000}, 0);
    do_mult("ffxff", 8'hFF, 8'hFF, 1'b1, 1'b0, SG ? {1'b0, 16'h0001} : {1'b0, 16'hFE01}, 0);
    do_mult("loadbusy", 8'h07, 8'h3B, 1'b1, 1'b1, {1'b0, 16'h019D}, 0);

    // Abort in the middle of an operation (ADD with cnt=3)
    @(negedge Clk); ClearA_LoadB = 1'b1; S = 8'h5A;
    @(negedge Clk); ClearA_LoadB = 1'b0; S = 8'h33; Run = 1'b1;
    repeat (8) @(negedge Clk);
    check("midop busy", {1'b0, Busy}, (2*W+2)'(1));
    #2 Reset = 1'b1;
    #1 check("midop reset", {Busy, Done, X, Aval, Bval}, '0);
    @(negedge Clk); Reset = 1'b0; Run = 1'b0;

    do_mult("5x6", 8'h05, 8'h06, 1'b1, 1'b0, {1'b0, 16'h001E}, 0);

    repeat (2) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
